thread_writeback: RTL and testbench

THREAD_WRITEBACK -- requirements
Module: thread_writeback

---
 rtl/thread_pkg.sv | 11 +
 rtl/thread_writeback_if.sv | 32 +++
 rtl/thread_wb_fifo.sv | 49 ++++
 rtl/thread_writeback.sv | 83 ++++++++
 tb/tb_thread_writeback.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/thread_pkg.sv
// Shared widths and the writeback entry type for the thread writeback block.
package thread_pkg;
    localparam int DATA_W = 28;
    localparam int NREG   = 16;
    localparam int AW     = $clog2(NREG);

    typedef struct packed {
        logic [AW-1:0]     dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/thread_writeback_if.sv
// Result sources, reservation port, register-file write port and scoreboard.
interface thread_writeback_if
    import thread_pkg::*;
#(
    parameter int DATA_W = thread_pkg::DATA_W,
    parameter int NREG   = thread_pkg::NREG,
    parameter int AW     = $clog2(NREG)
);
    logic              alu_valid, alu_ready;
    logic [AW-1:0]     alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [AW-1:0]     mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_dest;
    logic              wb_wen;
    logic [AW-1:0]     wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic [NREG-1:0]   busy;

    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
               rsv_valid, rsv_dest,
        input  alu_ready, mem_ready, wb_wen, wb_dest, wb_data, busy
    );
    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
               rsv_valid, rsv_dest,
        output alu_ready, mem_ready, wb_wen, wb_dest, wb_data, busy
    );
endinterface

// File: rtl/thread_wb_fifo.sv
// Small per-source result FIFO; ready is derived from registered occupancy only.
module thread_wb_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         ready,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Held low during reset so upstream never pushes into a FIFO being cleared.
    assign ready = (count != CW'(DEPTH)) && !rst;
    assign empty = (count == '0);
    assign dout  = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= din;
                wr_ptr        <= inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/thread_writeback.sv
// Round-robin merge of ALU and load results into the register-file write port,
// plus the pending-write scoreboard.
module thread_writeback
    import thread_pkg::*;
#(
    parameter int DATA_W     = thread_pkg::DATA_W,
    parameter int NREG       = thread_pkg::NREG,
    parameter int FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    thread_writeback_if.slave bus
);
    localparam int EW = $bits(wb_entry_t);

    wb_entry_t         alu_in, mem_in, alu_head, mem_head, win;
    logic              alu_push, mem_push, alu_rdy, mem_rdy, alu_empty, mem_empty;
    logic              grant_alu, grant_mem, pop, wr_fire;
    logic              last_alu;
    logic              wen_q;
    logic [AW-1:0]     dest_q;
    logic [DATA_W-1:0] data_q;
    logic [NREG-1:0]   busy_q, busy_nxt;

    assign alu_in   = '{dest: bus.alu_dest, data: bus.alu_data};
    assign mem_in   = '{dest: bus.mem_dest, data: bus.mem_data};
    assign alu_push = bus.alu_valid && alu_rdy;
    assign mem_push = bus.mem_valid && mem_rdy;

    thread_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk), .rst(rst), .push(alu_push), .din(alu_in), .ready(alu_rdy),
        .pop(grant_alu), .empty(alu_empty), .dout(alu_head)
    );
    thread_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk(clk), .rst(rst), .push(mem_push), .din(mem_in), .ready(mem_rdy),
        .pop(grant_mem), .empty(mem_empty), .dout(mem_head)
    );

    // last_alu=1 means mem wins the next tie.
    always_comb begin
        grant_mem = !mem_empty && (alu_empty || last_alu);
        grant_alu = !alu_empty && !grant_mem;
        pop       = grant_mem || grant_alu;
        win       = grant_mem ? mem_head : alu_head;
        wr_fire   = pop && (win.dest != '0);
    end

    // Set after clear so a same-edge re-reservation keeps the bit.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_fire)
            busy_nxt[win.dest] = 1'b0;
        if (bus.rsv_valid)
            busy_nxt[bus.rsv_dest] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_alu <= 1'b1;
            wen_q    <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
            busy_q   <= '0;
        end else begin
            if (pop)
                last_alu <= grant_alu;
            wen_q  <= wr_fire;
            busy_q <= busy_nxt;
            if (wr_fire) begin
                dest_q <= win.dest;
                data_q <= win.data;
            end
        end
    end

    assign bus.alu_ready = alu_rdy;
    assign bus.mem_ready = mem_rdy;
    assign bus.wb_wen    = wen_q;
    assign bus.wb_dest   = dest_q;
    assign bus.wb_data   = data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_thread_writeback.sv
// Directed bench for thread_writeback: inputs driven and outputs sampled on the falling edge.
module tb_thread_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    thread_writeback_if bus ();
    thread_writeback dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_dest = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_dest = 0; bus.mem_data = 0;
        bus.rsv_valid = 0; bus.rsv_dest = 0;
    endtask

    int          ai, mi, n, stall;
    logic        fa, fm;
    logic [3:0]  wq_dest [8];
    logic [27:0] wq_data [8];
    logic [3:0]  exp_dest [6];

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        check("rst_alu_ready", 32'(bus.alu_ready), 0);
        check("rst_mem_ready", 32'(bus.mem_ready), 0);
        rst = 0;
        #1;
        check("post_rst_alu_ready", 32'(bus.alu_ready), 1);
        check("post_rst_mem_ready", 32'(bus.mem_ready), 1);
        check("rst_wen", 32'(bus.wb_wen), 0);
        check("rst_dest", 32'(bus.wb_dest), 0);
        check("rst_data", 32'(bus.wb_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        tick();

        // Single ALU push: write appears one cycle after the push edge, for one cycle.
        bus.alu_valid = 1; bus.alu_dest = 5; bus.alu_data = 28'h0ABCDEF;
        tick();
        idle();
        check("single_wen_early", 32'(bus.wb_wen), 0);
        tick();
        check("single_wen", 32'(bus.wb_wen), 1);
        check("single_dest", 32'(bus.wb_dest), 5);
        check("single_data", 32'(bus.wb_data), 32'h0ABCDEF);
        tick();
        check("single_wen_drop", 32'(bus.wb_wen), 0);
        check("single_dest_hold", 32'(bus.wb_dest), 5);
        check("single_data_hold", 32'(bus.wb_data), 32'h0ABCDEF);

        // Both sources streaming: mem,alu alternate starting with mem.
        ai = 0; mi = 0; n = 0; stall = 0;
        for (int c = 0; c < 20; c++) begin
            bus.alu_valid = (ai < 3); bus.alu_dest = 4'(ai + 1); bus.alu_data = 28'(32'h100 + ai + 1);
            bus.mem_valid = (mi < 3); bus.mem_dest = 4'(mi + 4); bus.mem_data = 28'(32'h200 + mi + 4);
            fa = bus.alu_valid && bus.alu_ready;
            fm = bus.mem_valid && bus.mem_ready;
            if (bus.alu_valid && !bus.alu_ready) stall++;
            tick();
            if (fa) ai++;
            if (fm) mi++;
            if (bus.wb_wen && n < 8) begin
                wq_dest[n] = bus.wb_dest;
                wq_data[n] = bus.wb_data;
                n++;
            end
        end
        idle();
        exp_dest = '{4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3};
        check("stream_count", 32'(n), 6);
        check("stream_alu_stalled", 32'(stall > 0), 1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("stream_dest%0d", k), 32'(wq_dest[k]), 32'(exp_dest[k]));
            check($sformatf("stream_data%0d", k), 32'(wq_data[k]),
                  (exp_dest[k] >= 4) ? 32'h200 + 32'(exp_dest[k]) : 32'h100 + 32'(exp_dest[k]));
        end

        // Scoreboard: reserve 7, clear on write, same-edge re-reservation holds it.
        bus.rsv_valid = 1; bus.rsv_dest = 7;
        tick();
        idle();
        check("rsv7_set", 32'(bus.busy), 32'h0080);
        tick();
        check("rsv7_hold", 32'(bus.busy), 32'h0080);
        bus.alu_valid = 1; bus.alu_dest = 7; bus.alu_data = 28'h777;
        tick();
        idle();
        check("rsv7_pending", 32'(bus.busy), 32'h0080);
        bus.rsv_valid = 1; bus.rsv_dest = 7;
        tick();
        idle();
        check("rsv7_wen", 32'(bus.wb_wen), 1);
        check("rsv7_reres", 32'(bus.busy), 32'h0080);
        bus.alu_valid = 1; bus.alu_dest = 7; bus.alu_data = 28'h778;
        tick();
        idle();
        check("rsv7_still", 32'(bus.busy), 32'h0080);
        tick();
        check("rsv7_wen2", 32'(bus.wb_wen), 1);
        check("rsv7_clear", 32'(bus.busy), 0);

        // Destination 0: consumed silently; reservation of 0 ignored.
        bus.mem_valid = 1; bus.mem_dest = 0; bus.mem_data = 28'hFFFFFFF;
        bus.rsv_valid = 1; bus.rsv_dest = 0;
        tick();
        bus.rsv_valid = 0;
        bus.mem_dest = 9; bus.mem_data = 28'h999;
        check("r0_busy", 32'(bus.busy), 0);
        tick();
        idle();
        check("r0_wen", 32'(bus.wb_wen), 0);
        check("r0_dest_hold", 32'(bus.wb_dest), 7);
        tick();
        check("r0_next_wen", 32'(bus.wb_wen), 1);
        check("r0_next_dest", 32'(bus.wb_dest), 9);
        check("r0_next_data", 32'(bus.wb_data), 32'h999);
        tick();

        // Reset mid-operation discards buffered results and reservations.
        bus.alu_valid = 1; bus.alu_dest = 1; bus.alu_data = 28'h11;
        bus.mem_valid = 1; bus.mem_dest = 2; bus.mem_data = 28'h22;
        bus.rsv_valid = 1; bus.rsv_dest = 3;
        tick();
        bus.alu_dest = 4; bus.mem_dest = 8; bus.rsv_dest = 9;
        tick();
        bus.rsv_valid = 0;
        tick();
        idle();
        check("pre_rst_busy", 32'(bus.busy), 32'h0208);
        rst = 1;
        tick();
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_wen", 32'(bus.wb_wen), 0);
        check("mid_rst_data", 32'(bus.wb_data), 0);
        check("mid_rst_ready", 32'({bus.alu_ready, bus.mem_ready}), 0);
        rst = 0;
        #1;
        check("after_rst_ready", 32'({bus.alu_ready, bus.mem_ready}), 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("after_rst_wen%0d", k), 32'(bus.wb_wen), 0);
            check($sformatf("after_rst_busy%0d", k), 32'(bus.busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
